// File: rtl/ramb16_s1_fifo_pkg.sv
// rtl/ramb16_s1_fifo_pkg.sv - shared constants and types for the RAMB16_S1 FIFO controller
package ramb16_s1_fifo_pkg;

    localparam int ADDR_W   = 14;
    localparam int DEPTH    = 2 ** ADDR_W;
    localparam int OQ_DEPTH = 2;
    localparam int LVL_W    = $clog2(OQ_DEPTH + 1);

    typedef logic [ADDR_W-1:0] ptr_t;
    typedef logic [ADDR_W:0]   cnt_t;
    typedef logic [LVL_W-1:0]  lvl_t;

    localparam cnt_t CNT_DEPTH = cnt_t'(DEPTH);

endpackage

// File: rtl/ramb16_s1_fifo_ctrl_if.sv
// rtl/ramb16_s1_fifo_ctrl_if.sv - push/pop valid-ready handshake bundle
interface ramb16_s1_fifo_ctrl_if;

    logic wr_valid;
    logic wr_ready;
    logic wr_data;
    logic rd_valid;
    logic rd_ready;
    logic rd_data;

    modport master (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data
    );

    modport slave (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data
    );

endinterface

// File: rtl/ramb16_s1_fifo_oq.sv
// rtl/ramb16_s1_fifo_oq.sv - two-entry output queue feeding the pop port
module ramb16_s1_fifo_oq
    import ramb16_s1_fifo_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_din,
    input  logic i_pop,
    output lvl_t o_level,
    output logic o_head
);

    lvl_t r_level;
    logic r_q0;
    logic r_q1;

    // r_q0 is always the head; a simultaneous load+pop on a single entry replaces it in place
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_level <= '0;
            r_q0    <= 1'b0;
            r_q1    <= 1'b0;
        end else begin
            case ({i_load, i_pop})
                2'b10: begin
                    if (r_level == lvl_t'(0)) r_q0 <= i_din;
                    else                      r_q1 <= i_din;
                    r_level <= r_level + lvl_t'(1);
                end
                2'b01: begin
                    r_q0    <= r_q1;
                    r_level <= r_level - lvl_t'(1);
                end
                2'b11: begin
                    if (r_level == lvl_t'(1)) begin
                        r_q0 <= i_din;
                    end else begin
                        r_q0 <= r_q1;
                        r_q1 <= i_din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_level = r_level;
    assign o_head  = r_q0;

endmodule

// File: rtl/ramb16_s1_fifo_ctrl.sv
// rtl/ramb16_s1_fifo_ctrl.sv - bit-serial FIFO controller driving a 16Kx1 single-port RAM
// Optional macro RAMB16_S1_FIFO_BYPASS_EN lets pushes into a drained FIFO skip the RAM.
module ramb16_s1_fifo_ctrl
    import ramb16_s1_fifo_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    ramb16_s1_fifo_ctrl_if.slave fifo_if,
    output cnt_t                 o_count,
    output logic                 o_full,
    output logic                 o_empty,
    output ptr_t                 o_ram_addr,
    output logic                 o_ram_di,
    output logic                 o_ram_en,
    output logic                 o_ram_we,
    output logic                 o_ram_ssr,
    input  logic                 i_ram_do
);

    ptr_t r_wr_ptr;
    ptr_t r_rd_ptr;
    cnt_t r_ram_cnt;
    logic r_inflight;

    lvl_t       w_oq_level;
    logic       w_oq_head;
    logic       w_pop;
    logic [2:0] w_level;
    logic       w_pf_ok;
    logic       w_urgent;
    logic       w_full;
    logic       w_wr_ready;
    logic       w_wr_fire;
    logic       w_byp;
    logic       w_wr_ram;
    logic       w_rd_gnt;
    logic       w_load;
    logic       w_load_data;
    cnt_t       w_count;

    assign w_pop   = fifo_if.rd_ready && (w_oq_level != lvl_t'(0));
    // Projected queue fill after this cycle's pop, counting the read already in flight
    assign w_level = 3'(w_oq_level) + 3'(r_inflight) - 3'(w_pop);
    assign w_pf_ok  = (r_ram_cnt != '0) && (w_level < 3'd2);
    assign w_urgent = w_pf_ok && (w_level == 3'd0);
    assign w_full   = (r_ram_cnt == CNT_DEPTH);

    assign w_wr_ready = i_rst_n && !w_full && !w_urgent;
    assign w_wr_fire  = fifo_if.wr_valid && w_wr_ready;

`ifdef RAMB16_S1_FIFO_BYPASS_EN
    assign w_byp = w_wr_fire && (r_ram_cnt == '0) && !r_inflight && (w_level < 3'd2);
`else
    assign w_byp = 1'b0;
`endif

    assign w_wr_ram    = w_wr_fire && !w_byp;
    assign w_rd_gnt    = w_pf_ok && (w_urgent || !w_wr_fire);
    assign w_load      = r_inflight || w_byp;
    assign w_load_data = r_inflight ? i_ram_do : fifo_if.wr_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ram_cnt  <= '0;
            r_inflight <= 1'b0;
        end else begin
            if (w_wr_ram) r_wr_ptr <= r_wr_ptr + ptr_t'(1);
            if (w_rd_gnt) r_rd_ptr <= r_rd_ptr + ptr_t'(1);
            r_inflight <= w_rd_gnt;
            case ({w_wr_ram, w_rd_gnt})
                2'b10:   r_ram_cnt <= r_ram_cnt + cnt_t'(1);
                2'b01:   r_ram_cnt <= r_ram_cnt - cnt_t'(1);
                default: r_ram_cnt <= r_ram_cnt;
            endcase
        end
    end

    ramb16_s1_fifo_oq u_oq (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_load),
        .i_din   (w_load_data),
        .i_pop   (w_pop),
        .o_level (w_oq_level),
        .o_head  (w_oq_head)
    );

    assign w_count = r_ram_cnt + cnt_t'(r_inflight) + cnt_t'(w_oq_level);

    assign fifo_if.wr_ready = w_wr_ready;
    assign fifo_if.rd_valid = (w_oq_level != lvl_t'(0));
    assign fifo_if.rd_data  = w_oq_head;

    assign o_count    = w_count;
    assign o_full     = w_full;
    assign o_empty    = (w_count == '0);
    assign o_ram_addr = w_wr_fire ? r_wr_ptr : r_rd_ptr;
    assign o_ram_di   = fifo_if.wr_data;
    assign o_ram_en   = w_wr_ram || w_rd_gnt;
    assign o_ram_we   = w_wr_ram;
    assign o_ram_ssr  = 1'b0;

endmodule
